// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op-codes, the default execute-state
// encoding, NZP bit positions and the control FSM states.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [2:0] EXEC_STATE_DEF = 3'b101;

    // CMP result bit positions in alu_out: N = rs<rt, Z = rs==rt, P = rs>rt
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_DIV_RUN = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle (DATA_W cycles).
// Only instantiated when ALU_DIV_EN is defined; quotient/remainder are valid while done_o is high.
module alu_divider #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   trial;

    // quo_q starts as the dividend; its MSB shifts into the partial remainder while
    // quotient bits shift in at the bottom, so after DATA_W steps it holds the quotient.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_o  = 1'b0;
        partial = {rem_q, quo_q[DATA_W-1]};
        trial   = partial - {1'b0, dsr_q};

        if (busy_q) begin
            if (trial[DATA_W]) begin
                rem_d = partial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end else begin
                rem_d = trial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                done_o = 1'b1;
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            quo_d  = dividend_i;
            dsr_d  = divisor_i;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/alu_multicycle.sv
// Per-lane execute-stage ALU: single-cycle ADD/SUB/MUL/CMP plus a multicycle DIV with
// start/busy/valid handshake. Define ALU_DIV_EN to include the iterative divider.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter logic [2:0] EXEC_STATE = EXEC_STATE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2:0]        core_state,
    input  logic [1:0]        decoded_alu_arithmetic_mux,
    input  logic              decoded_alu_output_mux,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] alu_rem,
    output logic              alu_carry,
    output logic              alu_valid,
    output logic              alu_busy
);

    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              carry_q, carry_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] res_out, res_rem;
    logic              res_carry;
    logic [DATA_W:0]   sum;

    logic              idle, accept, long_div;
    logic              div_done, div_busy;
    logic [DATA_W-1:0] div_quo, div_rem;

    assign accept = idle && enable && (core_state == EXEC_STATE);

`ifdef ALU_DIV_EN
    alu_state_e state_q, state_d;

    assign idle     = (state_q == S_IDLE);
    assign long_div = !decoded_alu_output_mux && (decoded_alu_arithmetic_mux == OP_DIV) && (rt != '0);

    alu_divider #(.DATA_W(DATA_W)) u_divider (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (accept && long_div),
        .dividend_i  (rs),
        .divisor_i   (rt),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept && long_div) state_d = S_DIV_RUN;
            S_DIV_RUN: if (div_done)           state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end
`else
    assign idle     = 1'b1;
    assign long_div = 1'b0;
    assign div_done = 1'b0;
    assign div_busy = 1'b0;
    assign div_quo  = '0;
    assign div_rem  = '0;
`endif

    always_comb begin
        res_out   = '0;
        res_rem   = '0;
        res_carry = 1'b0;
        sum       = {1'b0, rs} + {1'b0, rt};
        if (decoded_alu_output_mux) begin
            res_out[NZP_N] = (rs < rt);
            res_out[NZP_Z] = (rs == rt);
            res_out[NZP_P] = (rs > rt);
        end else begin
            case (decoded_alu_arithmetic_mux)
                OP_ADD: {res_carry, res_out} = sum;
                OP_SUB: begin
                    res_out   = rs - rt;
                    res_carry = (rs < rt);
                end
                OP_MUL: res_out = rs * rt;
                OP_DIV: begin
`ifdef ALU_DIV_EN
                    // Divide-by-zero completes immediately with the dividend as remainder.
                    if (rt == '0) res_rem = rs;
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs change only on a completed op; the long divide reports from div_done instead.
    always_comb begin
        out_d   = out_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        if (accept && !long_div) begin
            out_d   = res_out;
            rem_d   = res_rem;
            carry_d = res_carry;
            valid_d = 1'b1;
        end else if (div_done) begin
            out_d   = div_quo;
            rem_d   = div_rem;
            carry_d = 1'b0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign alu_out   = out_q;
    assign alu_rem   = rem_q;
    assign alu_carry = carry_q;
    assign alu_valid = valid_q;
    assign alu_busy  = div_busy;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (DATA_W=8): directed spec cases plus randomized
// ops compared against an arithmetic reference model; expectations follow ALU_DIV_EN.
module tb_alu_multicycle;

    localparam int         DATA_W = 8;
    localparam int         MOD    = 1 << DATA_W;
    localparam logic [2:0] EXEC   = 3'b101;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [2:0]        core_state;
    logic [1:0]        arith;
    logic              outmux;
    logic [DATA_W-1:0] rs, rt;
    logic [DATA_W-1:0] alu_out, alu_rem;
    logic              alu_carry, alu_valid, alu_busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] prev_out, prev_rem;
    logic              prev_carry;

    alu_multicycle #(.DATA_W(DATA_W), .EXEC_STATE(EXEC)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .enable                     (enable),
        .core_state                 (core_state),
        .decoded_alu_arithmetic_mux (arith),
        .decoded_alu_output_mux     (outmux),
        .rs                         (rs),
        .rt                         (rt),
        .alu_out                    (alu_out),
        .alu_rem                    (alu_rem),
        .alu_carry                  (alu_carry),
        .alu_valid                  (alu_valid),
        .alu_busy                   (alu_busy)
    );

    always #5 clk = ~clk;

    // Reference model straight from the arithmetic definitions of each op.
    function automatic void model(input logic [1:0] op, input logic cmp, input int a, input int b,
                                  output logic [DATA_W-1:0] o, output logic [DATA_W-1:0] r,
                                  output logic c);
        int s;
        o = '0;
        r = '0;
        c = 1'b0;
        if (cmp) begin
            if (a < b)       o = DATA_W'(4);
            else if (a == b) o = DATA_W'(2);
            else             o = DATA_W'(1);
        end else begin
            case (op)
                2'b00: begin
                    s = a + b;
                    o = DATA_W'(s % MOD);
                    c = (s >= MOD);
                end
                2'b01: begin
                    o = DATA_W'((a - b + MOD) % MOD);
                    c = (a < b);
                end
                2'b10: o = DATA_W'((a * b) % MOD);
                default: begin
                    if (DIV_EN) begin
                        if (b == 0) r = DATA_W'(a);
                        else begin
                            o = DATA_W'(a / b);
                            r = DATA_W'(a % b);
                        end
                    end
                end
            endcase
        end
    endfunction

    // Issue one op, follow it to its valid pulse and check latency, hold behaviour and result.
    task automatic run_op(input logic [1:0] op, input logic cmp, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input bit chain, input bit disturb,
                          input string name);
        logic [DATA_W-1:0] eo, er;
        logic              ec;
        int                lat, k;
        model(op, cmp, int'(a), int'(b), eo, er, ec);
        lat = (DIV_EN && !cmp && op == 2'b11 && b != 0) ? DATA_W : 0;
        @(negedge clk);
        enable = 1'b1; core_state = EXEC; arith = op; outmux = cmp; rs = a; rt = b;
        @(posedge clk); #1;
        enable = 1'b0;
        k = 0;
        while (alu_valid !== 1'b1 && k < lat + 3) begin
            vectors++;
            if ({alu_busy, alu_out, alu_rem} !== {1'b1, prev_out, prev_rem}) begin
                miscompares++;
                $display("FAIL %s hold k=%0d: busy/out/rem got %b/%0d/%0d want 1/%0d/%0d",
                         name, k, alu_busy, alu_out, alu_rem, prev_out, prev_rem);
            end
            if (disturb && k >= 1 && k <= lat - 3) begin
                enable = 1'($urandom); core_state = 3'($urandom); arith = 2'($urandom);
                rs = DATA_W'($urandom); rt = DATA_W'($urandom);
            end else begin
                enable = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        vectors++;
        if (alu_valid !== 1'b1 || k != lat) begin
            miscompares++;
            $display("FAIL %s latency: valid=%b after %0d cycles, want valid=1 after %0d",
                     name, alu_valid, k, lat);
        end
        vectors++;
        if ({alu_out, alu_rem, alu_carry, alu_busy} !== {eo, er, ec, 1'b0}) begin
            miscompares++;
            $display("FAIL %s result: out/rem/carry/busy got %0d/%0d/%b/%b want %0d/%0d/%b/0",
                     name, alu_out, alu_rem, alu_carry, alu_busy, eo, er, ec);
        end
        prev_out = eo; prev_rem = er; prev_carry = ec;
        if (!chain) begin
            @(posedge clk); #1;
            vectors++;
            if (alu_valid !== 1'b0 || alu_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s pulse end: valid/busy got %b/%b want 0/0", name, alu_valid, alu_busy);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({alu_out, alu_rem, alu_carry, alu_valid, alu_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: out/rem/carry/valid/busy got %0d/%0d/%b/%b/%b want all 0",
                     alu_out, alu_rem, alu_carry, alu_valid, alu_busy);
        end
        @(negedge clk) reset_n = 1'b1;
        run_op(2'b00, 1'b0, 8'd100, 8'd27, 1'b0, 1'b0, "pre_reset_add");
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({alu_out, alu_rem, alu_carry, alu_valid, alu_busy} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: out/rem/carry/valid/busy got %0d/%0d/%b/%b/%b want all 0",
                     alu_out, alu_rem, alu_carry, alu_valid, alu_busy);
        end
        @(negedge clk) reset_n = 1'b1;
        prev_out = '0; prev_rem = '0; prev_carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (alu_valid !== 1'b0 || alu_out !== '0) begin
                miscompares++;
                $display("FAIL post_reset_idle: valid/out got %b/%0d want 0/0", alu_valid, alu_out);
            end
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 1'b0, 8'd200, 8'd100, 1'b0, 1'b0, "add_200_100");
        run_op(2'b01, 1'b0, 8'd5,   8'd7,   1'b0, 1'b0, "sub_5_7");
        run_op(2'b10, 1'b0, 8'd20,  8'd13,  1'b0, 1'b0, "mul_20_13");
        run_op(2'b00, 1'b1, 8'd9,   8'd9,   1'b0, 1'b0, "cmp_eq");
        run_op(2'b11, 1'b1, 8'd3,   8'd9,   1'b0, 1'b0, "cmp_lt");
        run_op(2'b01, 1'b1, 8'd9,   8'd3,   1'b0, 1'b0, "cmp_gt");
        run_op(2'b11, 1'b0, 8'd55,  8'd0,   1'b0, 1'b0, "div_by_zero");
        run_op(2'b11, 1'b0, 8'd200, 8'd7,   1'b0, 1'b0, "div_200_7");
        run_op(2'b00, 1'b0, 8'd255, 8'd1,   1'b0, 1'b0, "add_wrap");
        run_op(2'b01, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, "sub_zero");
        run_op(2'b11, 1'b0, 8'd255, 8'd1,   1'b0, 1'b0, "div_by_one");
        run_op(2'b11, 1'b0, 8'd7,   8'd200, 1'b0, 1'b0, "div_small");
        run_op(2'b11, 1'b0, 8'd255, 8'd255, 1'b0, 1'b0, "div_equal");
    endtask

    task automatic test_gating();
        logic [2:0] cs;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 6) begin
                cs = 3'($urandom_range(0, 6));
                if (cs >= 3'd5) cs = cs + 3'd1;
                enable = 1'b1; core_state = cs;
            end else begin
                enable = 1'b0; core_state = EXEC;
            end
            arith = 2'($urandom); outmux = 1'($urandom);
            rs = DATA_W'($urandom); rt = DATA_W'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({alu_valid, alu_busy, alu_out, alu_rem, alu_carry} !== {2'b00, prev_out, prev_rem, prev_carry}) begin
                miscompares++;
                $display("FAIL gating en=%b cs=%0d: valid/busy/out got %b/%b/%0d want 0/0/%0d",
                         enable, core_state, alu_valid, alu_busy, alu_out, prev_out);
            end
        end
        @(negedge clk) enable = 1'b0;
    endtask

    task automatic test_div_disturb();
        run_op(2'b11, 1'b0, 8'd200, 8'd7, 1'b0, 1'b1, "div_disturb");
    endtask

    task automatic test_back_to_back();
        run_op(2'b00, 1'b0, 8'd17,  8'd250, 1'b1, 1'b0, "b2b_add");
        run_op(2'b10, 1'b0, 8'd33,  8'd9,   1'b1, 1'b0, "b2b_mul");
        run_op(2'b11, 1'b0, 8'd200, 8'd7,   1'b1, 1'b0, "b2b_div");
        run_op(2'b01, 1'b0, 8'd1,   8'd2,   1'b1, 1'b0, "b2b_sub");
        run_op(2'b11, 1'b0, 8'd77,  8'd0,   1'b1, 1'b0, "b2b_div0");
        run_op(2'b11, 1'b0, 8'd250, 8'd13,  1'b0, 1'b0, "b2b_div_last");
    endtask

    task automatic test_abort();
        @(negedge clk);
        enable = 1'b1; core_state = EXEC; arith = 2'b11; outmux = 1'b0; rs = 8'd200; rt = 8'd7;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        vectors++;
        if ({alu_busy, alu_valid, alu_out, alu_rem, alu_carry} !== '0) begin
            miscompares++;
            $display("FAIL abort_reset: busy/valid/out/rem got %b/%b/%0d/%0d want 0/0/0/0",
                     alu_busy, alu_valid, alu_out, alu_rem);
        end
        @(negedge clk) reset_n = 1'b1;
        prev_out = '0; prev_rem = '0; prev_carry = 1'b0;
        for (int i = 0; i < DATA_W + 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (alu_valid !== 1'b0 || alu_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet cycle %0d: valid/busy got %b/%b want 0/0", i, alu_valid, alu_busy);
            end
        end
        run_op(2'b00, 1'b0, DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0, "after_abort_add");
        run_op(2'b11, 1'b0, 8'd200, 8'd7, 1'b0, 1'b0, "after_abort_div");
    endtask

    task automatic test_random();
        logic [1:0]        op;
        logic              cmp;
        logic [DATA_W-1:0] a, b;
        for (int i = 0; i < 48; i++) begin
            op  = 2'($urandom);
            cmp = ($urandom_range(0, 4) == 0);
            a   = DATA_W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = a;
                default: b = DATA_W'($urandom);
            endcase
            run_op(op, cmp, a, b, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; core_state = 3'd0; arith = 2'b00; outmux = 1'b0;
        rs = '0; rt = '0;
        prev_out = '0; prev_rem = '0; prev_carry = 1'b0;
        test_reset();
        test_directed();
        test_gating();
        test_div_disturb();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
